toy_cpu_param: RTL
==================

// Module: toy_cpu_param
// PURPOSE
//  Parametrised successor of the team's 4-bit toy accumulator CPU core; sits behind the tt_um pad wrapper.
//  Fetches and executes one-word instructions from an external asynchronous memory over addr/data_in/data_out/we.
//  Data and address widths are generic. Adds HLT with a halted flag, a wider ISA and a full-state scan chain (shift in and out).
// PARAMETERS
//  DATA_W  8  data/instruction word width; must satisfy DATA_W >= ADDR_W+4
//  ADDR_W  4  address width; memory holds 2**ADDR_W words
// PORTS
//  clk       in   1       single clock, rising edge
//  rst       in   1       asynchronous, active-high reset
//  scan_en   in   1       1 = freeze execution and shift the scan chain
//  scan_in   in   1       serial scan input, enters the chain LSB
//  scan_out  out  1       chain MSB
//  addr      out  ADDR_W  memory address
//  data_out  out  DATA_W  write data; always equals acc
//  data_in   in   DATA_W  read data, combinational from addr
//  we        out  1       memory write enable
//  halted    out  1       1 while state==HALT
// BEHAVIOUR
//  Registers: pc[ADDR_W], ir[DATA_W], acc[DATA_W], state[1:0] (FETCH=00, EXEC=01, HALT=10; 11 -> FETCH next clk).
//  Reset values: pc=0, ir=0, acc=0, state=FETCH, so addr=0, we=0, data_out=0, halted=0, scan_out=0.
//  Decode: op=ir[DATA_W-1 -: 4]; opnd=ir[ADDR_W-1:0]; imm=ir[DATA_W-5:0], zero-extended.
//  FETCH: addr=pc, we=0; on clk ir<=data_in, pc<=pc+1 (wraps 2**ADDR_W-1 -> 0), state<=EXEC.
//  EXEC: addr=opnd; we=1 only for STA. On clk the op completes and state<=FETCH (HLT: state<=HALT).
//  2 cycles per instruction, fixed; no stalls.
//  Opcodes:
//   0 NOP; 1 LDA acc<=M; 2 STA M<=acc; 3 ADD acc<=acc+M; 4 SUB acc<=acc-M
//   5 AND; 6 OR; 7 XOR (acc<=acc op M); 8 LDI acc<=imm; 9 JMP pc<=opnd
//   A JZ  pc<=opnd if acc==0; B JNZ pc<=opnd if acc!=0
//   C SHL acc<=acc<<1; D SHR acc<=acc>>1 (logical); E see CONFIGURATION; F HLT
//  M = data_in sampled in EXEC. Arithmetic is modulo 2**DATA_W; overflow is discarded.
//  JZ/JNZ test acc as it stands at the start of EXEC.
//  HALT: addr=pc, we=0, state held; only rst or a scan load leaves HALT.
//  Scan: while scan_en=1, no architectural update; we forced 0; addr=pc.
//   Chain MSB->LSB = {state, pc, ir, acc[, c]}; each clk shifts left by 1; scan_in fills the LSB.
//   scan_out = chain MSB (combinational from the registers).
//   Chain length L = 2+ADDR_W+2*DATA_W (+1 with carry).
//   Deasserting scan_en resumes from the loaded state on the next clk.
//  rst mid-instruction or mid-scan: all registers return to reset values immediately (async). Memory writes in flight are aborted: we drops to 0.
// CONFIGURATION
//  TOYCPU_CARRY_EN defined:
//   - adds carry flag c (reset 0; appended as the chain LSB).
//   - ADD sets c=carry-out; SUB sets c=borrow (acc<M unsigned); SHL c<=acc[MSB]; SHR c<=acc[0].
//   - op E = JC: pc<=opnd if c==1.
//  Not defined: no c register; op E executes as NOP; L excludes the carry bit.
// TESTING
//  Reset: assert rst mid-EXEC of STA -> same cycle we=0, addr=0, data_out=0, halted=0, scan_out=0.
//  Program (8/4): LDI 5; ADD [E]=3; STA [F]; HLT -> mem[F]=8 written with we=1 for exactly one cycle in EXEC of STA; halted=1 after 8 clks; pc=4.
//  Loop: LDI 3; SUB [E]=1; JNZ 1; HLT -> SUB executes 3 times, acc=0, halted after 16 clks.
//  Wrap: pc=F fetching NOP -> pc=0 next. SUB 0-1 -> acc=FF. With TOYCPU_CARRY_EN: c=1 and JC is taken.
//  Scan: halt with acc=A5; scan_en for L clks while feeding the captured stream back -> state unchanged.
//   Then load pc=2, state=FETCH and drop scan_en -> execution resumes at 2.
//  Opcode E without TOYCPU_CARRY_EN -> acc and pc behave exactly as for NOP.

Source files
------------

// File: rtl/toy_cpu_param_if.sv
// Memory bus between toy_cpu_param and its asynchronous program/data memory.
// The CPU drives addr/data_out/we; the memory returns data_in combinationally from addr.
interface toy_cpu_param_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4
);
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data_out;
    logic [DATA_W-1:0] data_in;
    logic              we;

    modport master (output addr, output data_out, output we, input data_in);
    modport slave  (input addr, input data_out, input we, output data_in);
endinterface

// File: rtl/toy_cpu_param.sv
// toy_cpu_param: parametrised accumulator CPU with a 2-cycle fetch/execute loop and a full-state scan chain.
// Define TOYCPU_CARRY_EN to add the carry flag (chain LSB) and the JC opcode (0xE).
module toy_cpu_param #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            scan_en,
    input  logic            scan_in,
    output logic            scan_out,
    output logic            halted,
    toy_cpu_param_if.master mem
);
    typedef enum logic [1:0] {
        FETCH   = 2'b00,
        EXEC    = 2'b01,
        HALT    = 2'b10,
        ILLEGAL = 2'b11
    } state_t;

    localparam logic [3:0] OP_NOP = 4'h0, OP_LDA = 4'h1, OP_STA = 4'h2, OP_ADD = 4'h3;
    localparam logic [3:0] OP_SUB = 4'h4, OP_AND = 4'h5, OP_OR  = 4'h6, OP_XOR = 4'h7;
    localparam logic [3:0] OP_LDI = 4'h8, OP_JMP = 4'h9, OP_JZ  = 4'hA, OP_JNZ = 4'hB;
    localparam logic [3:0] OP_SHL = 4'hC, OP_SHR = 4'hD, OP_JC  = 4'hE, OP_HLT = 4'hF;

`ifdef TOYCPU_CARRY_EN
    localparam int CARRY_W = 1;
`else
    localparam int CARRY_W = 0;
`endif
    localparam int CHAIN_W = 2 + ADDR_W + 2*DATA_W + CARRY_W;

    state_t              state;
    logic [ADDR_W-1:0]   pc;
    logic [DATA_W-1:0]   ir;
    logic [DATA_W-1:0]   acc;
    logic [3:0]          op;
    logic [ADDR_W-1:0]   opnd;
    logic [DATA_W-1:0]   imm;
    logic [CHAIN_W-1:0]  chain;
    logic [CHAIN_W-1:0]  chain_shift;

    assign op   = ir[DATA_W-1 -: 4];
    assign opnd = ir[ADDR_W-1:0];
    assign imm  = {4'b0000, ir[DATA_W-5:0]};

`ifdef TOYCPU_CARRY_EN
    logic              c;
    logic [DATA_W:0]   add_full;
    logic [DATA_W:0]   sub_full;

    // The extra top bit of each result is carry-out / borrow respectively.
    assign add_full = {1'b0, acc} + {1'b0, mem.data_in};
    assign sub_full = {1'b0, acc} - {1'b0, mem.data_in};
    assign chain    = {state, pc, ir, acc, c};
`else
    assign chain    = {state, pc, ir, acc};
`endif

    assign chain_shift  = {chain[CHAIN_W-2:0], scan_in};
    assign scan_out     = chain[CHAIN_W-1];
    assign halted       = (state == HALT);
    assign mem.data_out = acc;
    // Scan freezes the bus: address parks on pc and writes are suppressed.
    assign mem.addr     = (!scan_en && state == EXEC) ? opnd : pc;
    assign mem.we       = !scan_en && (state == EXEC) && (op == OP_STA);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= FETCH;
            pc    <= '0;
            ir    <= '0;
            acc   <= '0;
`ifdef TOYCPU_CARRY_EN
            c     <= 1'b0;
`endif
        end else if (scan_en) begin
            state <= state_t'(chain_shift[CHAIN_W-1 -: 2]);
            pc    <= chain_shift[CHAIN_W-3 -: ADDR_W];
            ir    <= chain_shift[CHAIN_W-3-ADDR_W -: DATA_W];
            acc   <= chain_shift[CHAIN_W-3-ADDR_W-DATA_W -: DATA_W];
`ifdef TOYCPU_CARRY_EN
            c     <= chain_shift[0];
`endif
        end else begin
            case (state)
                FETCH: begin
                    ir    <= mem.data_in;
                    pc    <= pc + ADDR_W'(1);
                    state <= EXEC;
                end
                EXEC: begin
                    state <= FETCH;
                    case (op)
                        OP_LDA: acc <= mem.data_in;
`ifdef TOYCPU_CARRY_EN
                        OP_ADD: {c, acc} <= add_full;
                        OP_SUB: {c, acc} <= sub_full;
                        OP_SHL: begin c <= acc[DATA_W-1]; acc <= acc << 1; end
                        OP_SHR: begin c <= acc[0];        acc <= acc >> 1; end
                        OP_JC:  if (c) pc <= opnd;
`else
                        OP_ADD: acc <= acc + mem.data_in;
                        OP_SUB: acc <= acc - mem.data_in;
                        OP_SHL: acc <= acc << 1;
                        OP_SHR: acc <= acc >> 1;
`endif
                        OP_AND: acc <= acc & mem.data_in;
                        OP_OR:  acc <= acc | mem.data_in;
                        OP_XOR: acc <= acc ^ mem.data_in;
                        OP_LDI: acc <= imm;
                        OP_JMP: pc  <= opnd;
                        OP_JZ:  if (acc == '0) pc <= opnd;
                        OP_JNZ: if (acc != '0) pc <= opnd;
                        OP_HLT: state <= HALT;
                        default: ;
                    endcase
                end
                HALT:    state <= HALT;
                default: state <= FETCH;
            endcase
        end
    end
endmodule
